mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of extra wait cycles before each response (legal range 0..15).
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning the word-address width of the internal store (2^ADDR_BITS x 16-bit words).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port MemRead  input  1  read request, a level held by the requester until MemReady.
REQ-006 SHALL have port MemWrite  input  1  write request, a level held by the requester until MemReady.
REQ-007 SHALL have port Addr  input  16  word address, valid while a request is high.
REQ-008 SHALL have port WriteData  input  16  store data, valid while MemWrite is high.
REQ-009 SHALL have port ReadData  output  16  load data, valid during the MemReady cycle and held until the next completed read.
REQ-010 SHALL have port MemReady  output  1  one-cycle completion strobe.
REQ-011 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port Error  output  1  one-cycle strobe, coincident with MemReady, flagging a rejected access.

Function
REQ-013 SHALL implement the states IDLE, WAIT, RESP and DRAIN.
REQ-014 IDLE: on an edge with MemRead or MemWrite high, SHALL capture Addr, WriteData and the operation, then go to WAIT (counter loaded with WAIT_CYCLES-1), or go straight to RESP when WAIT_CYCLES=0.
REQ-015 WAIT: SHALL decrement the counter each edge and go to RESP on the edge where the counter equals 0.
REQ-016 MemReady SHALL be high for exactly the one cycle spent in RESP, which begins WAIT_CYCLES edges after the capture edge.
REQ-017 Read: ReadData SHALL equal mem[captured Addr] during the RESP cycle.
REQ-018 Write: mem[captured Addr] SHALL be updated with the captured WriteData on the edge leaving RESP, and ReadData SHALL be unchanged.
REQ-019 RESP SHALL always go to DRAIN.
REQ-020 DRAIN SHALL go to IDLE on the first edge with MemRead=0 and MemWrite=0, so a held request never produces a second access.
REQ-021 A capture with MemRead=1 and MemWrite=1 SHALL follow the normal timing, perform no access, assert Error in the RESP cycle and leave ReadData unchanged.
REQ-022 A captured Addr with any of bits [15:ADDR_BITS] set SHALL perform no access, assert Error in the RESP cycle, drive ReadData to 0 for that cycle, and leave the store unchanged.
REQ-023 Request changes (Addr, WriteData, MemRead, MemWrite) outside IDLE SHALL be ignored, except as the DRAIN release condition.
REQ-024 The counter SHALL be 4 bits wide and SHALL never wrap; counting stops at 0.

Reset
REQ-025 Reset high SHALL immediately force IDLE and drive MemReady=0, Error=0, Busy=0, ReadData=16'h0000 and counter=0.
REQ-026 Reset asserted during WAIT or RESP SHALL cancel the access, and a cancelled write SHALL not modify the store.
REQ-027 Reset SHALL NOT clear the store contents.
REQ-028 The first capture SHALL be possible on the first rising edge after Reset deasserts.

Structure
REQ-029 The state encoding (IDLE=0, WAIT=1, RESP=2, DRAIN=3) and the WAIT_CYCLES/ADDR_BITS defaults SHALL reside in the shared package mem_pkg.
REQ-030 The storage SHALL be a sub-module mem_array (synchronous write, registered read, 16-bit data, ADDR_BITS address); the FSM, counter and error checks SHALL remain in mem_responder.

Verification
REQ-031 Scenario, WAIT_CYCLES=2: write 16'hBEEF to 16'h0010, then read 16'h0010 -> MemReady 2 edges after each capture, and ReadData=16'hBEEF in the read's RESP cycle.
REQ-032 Scenario, WAIT_CYCLES=0: read 16'h0000 after a prior write of 16'h1234 -> MemReady in the cycle after the capture edge, and ReadData=16'h1234.
REQ-033 Scenario: MemRead held high for 6 cycles after MemReady -> exactly one MemReady pulse, Busy high until the edge after release.
REQ-034 Scenario: MemRead=MemWrite=1 at 16'h0005, then read 16'h0005 -> first access gives Error=1 with the store unchanged; second read returns the old value.
REQ-035 Scenario, ADDR_BITS=8: write 16'hAAAA to 16'h0100 -> Error=1, ReadData=0 in RESP, and a subsequent read of 16'h0000 is unchanged.
REQ-036 Scenario: write 16'h5555 to 16'h0020 with Reset pulsed during WAIT -> no MemReady, all outputs 0, and a later read of 16'h0020 returns the pre-reset value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory responder.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } memState_t;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int ADDR_BITS_DEF   = 8;
  localparam int DATA_W          = 16;
endpackage

// File: rtl/mem_array.sv
// Word store: synchronous write, registered read, no reset so contents survive Reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 WriteEn,
  input  logic [ADDR_BITS-1:0] WriteAddr,
  input  logic [DATA_W-1:0]    WriteData,
  input  logic [ADDR_BITS-1:0] ReadAddr,
  output logic [DATA_W-1:0]    ReadData
);
  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge CLK) begin
    if (WriteEn) mem[WriteAddr] <= WriteData;
    ReadData <= mem[ReadAddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Level-handshake memory responder with programmable wait states, a drain
// state that swallows held requests, and rejection of dual-op / out-of-range accesses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       Addr,
  input  logic [15:0]       WriteData,
  output logic [15:0]       ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic              Error
);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  memState_t            state, nextState;
  logic [3:0]           waitCnt;
  logic                 capRead, capWrite;
  logic [15:0]          capAddr, capData, readHold, arrayData;
  logic                 request, badAddr, bothOps, readOk, doWrite;
  logic [ADDR_BITS-1:0] arrayRdAddr;

  assign request = MemRead | MemWrite;
  assign badAddr = (capAddr >> ADDR_BITS) != 16'h0;
  assign bothOps = capRead & capWrite;
  assign readOk  = capRead & ~capWrite & ~badAddr;
  // Write lands on the edge leaving RESP; a reset in RESP drops state first, cancelling it.
  assign doWrite = (state == RESP) & capWrite & ~capRead & ~badAddr;
  // In IDLE the read port follows Addr so zero-wait reads have data in RESP.
  assign arrayRdAddr = (state == IDLE) ? Addr[ADDR_BITS-1:0] : capAddr[ADDR_BITS-1:0];

  mem_array #(.ADDR_BITS(ADDR_BITS)) store (
    .CLK       (CLK),
    .WriteEn   (doWrite),
    .WriteAddr (capAddr[ADDR_BITS-1:0]),
    .WriteData (capData),
    .ReadAddr  (arrayRdAddr),
    .ReadData  (arrayData)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (request) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt == 4'd0) nextState = RESP;
      RESP:    nextState = DRAIN;
      DRAIN:   if (!request) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      waitCnt  <= 4'd0;
      capRead  <= 1'b0;
      capWrite <= 1'b0;
      capAddr  <= 16'h0;
      capData  <= 16'h0;
      readHold <= 16'h0;
    end else begin
      case (state)
        IDLE: if (request) begin
          capRead  <= MemRead;
          capWrite <= MemWrite;
          capAddr  <= Addr;
          capData  <= WriteData;
          waitCnt  <= WAIT_LOAD;
        end
        WAIT: if (waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
        RESP: if (readOk) readHold <= arrayData;
        default: ;
      endcase
    end
  end

  always_comb begin
    MemReady = 1'b0;
    Error    = 1'b0;
    Busy     = (state != IDLE);
    ReadData = readHold;
    if (state == RESP) begin
      MemReady = 1'b1;
      Error    = bothOps | badAddr;
      if (badAddr)     ReadData = 16'h0;
      else if (readOk) ReadData = arrayData;
    end
  end
endmodule
